// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge
// Description : Core-to-peripheral IO bridge with one-hot channel select,
//               acknowledge timeout and saturating fault counter.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bridge #(
    parameter int NCH     = 4,
    parameter int AW      = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [NCH-1:0]    p_sel,
    output logic [AW-1:0]     p_addr,
    output logic              p_write,
    output logic [31:0]       p_wdata,
    input  logic [NCH*32-1:0] p_rdata,
    input  logic [NCH-1:0]    p_ack,
    output logic [7:0]        fault_count
);

    localparam int         CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW:0] c_nch      = (CW+1)'(NCH);
    localparam logic [7:0]  c_tmo_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [AW-1:0]   r_addr;
    logic            r_write;
    logic [31:0]     r_wdata;
    logic [CW-1:0]   r_idx;
    logic [7:0]      r_wait;
    logic [31:0]     r_rdata;
    logic            r_fault;
    logic [7:0]      r_fault_count;

    logic [CW-1:0]   w_req_idx;
    logic            w_dec_err;
    logic            w_ack;
    logic            w_timeout;
    logic [31:0]     w_ch_rdata;
    logic [NCH-1:0]  w_sel_onehot;
    logic            w_unused_addr;

    assign w_req_idx     = req_addr[AW+CW-1:AW];
    assign w_dec_err     = ~req_addr[31] | ({1'b0, w_req_idx} >= c_nch);
    assign w_timeout     = (r_wait == c_tmo_last);
    // Only the window, index and bit 31 are decoded; the rest is don't-care.
    assign w_unused_addr = ^req_addr;

    // Only the registered channel's ack/rdata are ever looked at.
    always_comb begin
        w_ack        = 1'b0;
        w_ch_rdata   = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == CW'(i)) begin
                w_ack           = p_ack[i];
                w_ch_rdata      = p_rdata[32*i +: 32];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_dec_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_ack || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_idx         <= '0;
            r_wait        <= '0;
            r_rdata       <= '0;
            r_fault       <= 1'b0;
            r_fault_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr[AW-1:0];
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_idx   <= w_req_idx;
                        r_wait  <= '0;
                        r_rdata <= '0;
                        r_fault <= w_dec_err;
                    end
                end
                ST_ACCESS: begin
                    // Ack has priority over a timeout in the same cycle.
                    if (w_ack) begin
                        r_rdata <= r_write ? 32'd0 : w_ch_rdata;
                        r_fault <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (r_fault && (r_fault_count != 8'hFF)) begin
                        r_fault_count <= r_fault_count + 8'd1;
                    end
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = (r_state == ST_RESP) ? r_rdata : 32'd0;
    assign rsp_fault   = (r_state == ST_RESP) & r_fault;
    assign p_sel       = (r_state == ST_ACCESS) ? w_sel_onehot : '0;
    assign p_write     = (r_state == ST_ACCESS) & r_write;
    assign p_addr      = r_addr;
    assign p_wdata     = r_wdata;
    assign fault_count = r_fault_count;

endmodule
`default_nettype wire
